// File: rtl/fisr_seed_stage_if.sv
// Stream bundle between the upstream word source, the seed stage and the Newton stage.
interface fisr_seed_stage_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_ready;
  logic        ce_out;
  logic [31:0] Data_out1;
  logic [31:0] Data_out2;
  logic [1:0]  Class;
  logic        Last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, ce_out, Data_out1, Data_out2, Class, Last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, ce_out, Data_out1, Data_out2, Class, Last
  );
endinterface

// File: rtl/fisr_seed_stage.sv
// Fast inverse square root front end: classifies IEEE-754 singles and produces
// the halved input x2 and the bit-trick seed y0 for the Newton stage.
module fisr_seed_stage #(
  parameter logic [31:0] MAGIC = 32'h5F3759DF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fisr_seed_stage_if.slave io,
  output logic [CNT_W-1:0] Word_cnt,
  output logic [CNT_W-1:0] Frame_cnt
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_INF    = 2'b01,
    CLS_NAN    = 2'b10,
    CLS_ZERO   = 2'b11
  } cls_e;

  logic        rdy_en;
  logic        s1_valid;
  logic [31:0] s1_x;
  cls_e        s1_cls;
  logic        s1_last;
  logic        s2_valid;

  logic        s1_adv;
  logic        s_fire;
  logic        s1_move;
  cls_e        in_cls;
  logic [31:0] x2_nxt;
  logic [31:0] y0_nxt;

  assign s1_adv     = !s2_valid || io.m_ready;
  // rdy_en keeps s_ready low throughout reset and until the first edge after release
  assign io.s_ready = rdy_en && (!s1_valid || s1_adv);
  assign s_fire     = io.s_valid && io.s_ready;
  assign s1_move    = s1_valid && s1_adv;
  assign io.ce_out  = s2_valid && io.m_ready;

  always_comb begin
    logic [7:0]  e;
    logic [22:0] m;
    e = io.s_data[30:23];
    m = io.s_data[22:0];
    in_cls = CLS_NORMAL;
    if (e == '1 && m != '0)
      in_cls = CLS_NAN;
    else if (io.s_data[31] && io.s_data[30:0] != '0)
      in_cls = CLS_NAN;
    else if (e == '0)
      in_cls = CLS_INF;
    else if (e == '1)
      in_cls = CLS_ZERO;
  end

  always_comb begin
    logic [7:0] e;
    e      = s1_x[30:23];
    x2_nxt = '0;
    y0_nxt = '0;
    if (s1_cls == CLS_NORMAL) begin
      // Halving e==1 leaves the normal range; keep the hidden bit as a truncated denormal
      if (e == 8'd1)
        x2_nxt = {9'h000, 1'b1, s1_x[22:1]};
      else
        x2_nxt = {1'b0, 8'(e - 8'd1), s1_x[22:0]};
      y0_nxt = MAGIC - {1'b0, s1_x[31:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en       <= 1'b0;
      s1_valid     <= 1'b0;
      s1_x         <= '0;
      s1_cls       <= CLS_NORMAL;
      s1_last      <= 1'b0;
      s2_valid     <= 1'b0;
      io.Data_out1 <= '0;
      io.Data_out2 <= '0;
      io.Class     <= '0;
      io.Last      <= 1'b0;
      Word_cnt     <= '0;
      Frame_cnt    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (io.s_ready)
        s1_valid <= io.s_valid;
      if (s_fire) begin
        s1_x    <= io.s_data;
        s1_cls  <= in_cls;
        s1_last <= io.s_last;
      end
      if (s1_adv)
        s2_valid <= s1_valid;
      if (s1_move) begin
        io.Data_out1 <= x2_nxt;
        io.Data_out2 <= y0_nxt;
        io.Class     <= s1_cls;
        io.Last      <= s1_last;
      end
      if (io.ce_out) begin
        Word_cnt <= Word_cnt + CNT_W'(1);
        if (io.Last)
          Frame_cnt <= Frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fisr_seed_stage.sv
// Scoreboard bench for fisr_seed_stage: expected operands are queued at acceptance
// and compared on every launch strobe.
module tb_fisr_seed_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fisr_seed_stage_if bus ();
  fisr_seed_stage_if bus4 ();
  logic [15:0] word_cnt, frame_cnt;
  logic [3:0]  word_cnt4, frame_cnt4;

  fisr_seed_stage #(.MAGIC(32'h5F3759DF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .io(bus.slave), .Word_cnt(word_cnt), .Frame_cnt(frame_cnt)
  );

  fisr_seed_stage #(.MAGIC(32'h5F3759DF), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .io(bus4.slave), .Word_cnt(word_cnt4), .Frame_cnt(frame_cnt4)
  );

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  cls;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   occ = 0;
  int   strobes = 0;
  bit   en_m = 1'b0;
  logic [15:0] wc_m = '0;
  logic [15:0] fc_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t fisr_model(input logic [31:0] x, input logic last);
    exp_t r;
    logic [7:0]  e;
    logic [22:0] m;
    logic [7:0]  em1;
    e = x[30:23];
    m = x[22:0];
    em1 = e - 8'd1;
    r.last = last;
    r.d1 = '0;
    r.d2 = '0;
    if (e == 8'hFF && m != 0)          r.cls = 2'b10;
    else if (x[31] && x[30:0] != 0)    r.cls = 2'b10;
    else if (e == 8'h00)               r.cls = 2'b01;
    else if (e == 8'hFF)               r.cls = 2'b11;
    else                               r.cls = 2'b00;
    if (r.cls == 2'b00) begin
      if (e >= 8'd2) r.d1 = {1'b0, em1, m};
      else           r.d1 = {1'b0, 8'h00, 1'b1, m[22:1]};
      r.d2 = 32'h5F3759DF - {1'b0, x[31:1]};
    end
    return r;
  endfunction

  // Output monitor: strobes, counters and the s_ready rule, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("s_ready_in_reset", bus.s_ready, 0);
      check("ce_in_reset", bus.ce_out, 0);
      sb.delete();
      occ  = 0;
      wc_m = '0;
      fc_m = '0;
      en_m = 1'b0;
    end else begin
      check("s_ready", bus.s_ready, en_m && !(occ == 2 && !bus.m_ready));
      check("word_cnt", word_cnt, wc_m);
      check("frame_cnt", frame_cnt, fc_m);
      if (bus.ce_out) begin
        strobes++;
        if (sb.size() == 0) begin
          check("spurious_strobe", bus.ce_out, 0);
        end else begin
          e = sb.pop_front();
          check("x2", bus.Data_out1, e.d1);
          check("y0", bus.Data_out2, e.d2);
          check("class", bus.Class, e.cls);
          check("last", bus.Last, e.last);
          wc_m = wc_m + 16'd1;
          if (e.last) fc_m = fc_m + 16'd1;
        end
      end
      occ  = occ + int'(bus.s_valid && bus.s_ready) - int'(bus.ce_out);
      en_m = 1'b1;
    end
  end

  task automatic send(input logic [31:0] x, input logic last);
    bit acc;
    int unsigned guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = x;
    bus.s_last  = last;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", acc, 1);
    else      sb.push_back(fisr_model(x, last));
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  bit tx_done;
  int s_before;
  int n4;
  int unsigned g4;
  bit a4;

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
    bus4.s_valid = 1'b0; bus4.s_data = '0; bus4.s_last = 1'b0; bus4.m_ready = 1'b1;

    // Reset state
    #12;
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_ce", bus.ce_out, 0);
    check("rst_x2", bus.Data_out1, 0);
    check("rst_y0", bus.Data_out2, 0);
    check("rst_class", bus.Class, 0);
    check("rst_last", bus.Last, 0);
    check("rst_word_cnt", word_cnt, 0);
    do_reset();
    check("ready_after_release", bus.s_ready, 1);

    // x=4.0 latency and operands
    send(32'h40800000, 1'b0);
    check("lat_ce_early", bus.ce_out, 0);
    @(posedge clk); #1;
    check("lat_ce", bus.ce_out, 1);
    check("lat_x2", bus.Data_out1, 32'h40000000);
    check("lat_y0", bus.Data_out2, 32'h3EF759DF);
    check("lat_class", bus.Class, 0);
    drain();

    // Back-to-back classes
    s_before = strobes;
    send(32'h3F800000, 1'b0);
    send(32'h00000000, 1'b0);
    send(32'hBF800000, 1'b0);
    send(32'h7FC00000, 1'b0);
    send(32'h7F800000, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    check("b2b_strobes", strobes - s_before, 5);
    drain();

    // e==1 truncated denormal halving
    send(32'h00800000, 1'b0);
    @(posedge clk); #1;
    check("e1_x2", bus.Data_out1, 32'h00400000);
    check("e1_y0", bus.Data_out2, 32'h5EF759DF);
    drain();

    // Frame of four words
    do_reset();
    for (int i = 0; i < 4; i++) send(32'h3F800000 + 32'(i << 20), i == 3);
    drain();
    check("frame_word_cnt", word_cnt, 4);
    check("frame_frame_cnt", frame_cnt, 1);

    // Random stream under 3-low/2-high backpressure
    s_before = strobes;
    tx_done = 1'b0;
    fork
      begin
        while (!tx_done) begin
          bus.m_ready = 1'b0;
          repeat (3) begin @(posedge clk); #1; end
          bus.m_ready = 1'b1;
          repeat (2) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send($urandom, i == 9);
        end
        tx_done = 1'b1;
      end
    join
    bus.m_ready = 1'b1;
    drain();
    check("stream_strobes", strobes - s_before, 10);

    // Reset with two words in flight
    bus.m_ready = 1'b0;
    send(32'h40800000, 1'b0);
    send(32'h41000000, 1'b0);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    check("mid_rst_ce", bus.ce_out, 0);
    check("mid_rst_x2", bus.Data_out1, 0);
    check("mid_rst_y0", bus.Data_out2, 0);
    check("mid_rst_class", bus.Class, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    send(32'h3F800000, 1'b0);
    drain();
    check("post_rst_word_cnt", word_cnt, 1);

    // Narrow counter wrap: 17 launches on a 4-bit counter
    n4 = 0;
    g4 = 0;
    bus4.s_valid = 1'b1;
    bus4.s_data  = 32'h3F800000;
    while (n4 < 17 && g4 < 200) begin
      @(negedge clk);
      a4 = bus4.s_ready;
      @(posedge clk); #1;
      if (a4) n4++;
      g4++;
    end
    bus4.s_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("wrap4_accepts", n4, 17);
    check("wrap4_word_cnt", word_cnt4, 4'd1);
    check("wrap4_frame_cnt", frame_cnt4, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
